// File: rtl/tile_mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tile_mem_arbiter_if -- requester command/response and bank port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface tile_mem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]                  req_i;
  logic [N_REQ-1:0]                  gnt_o;
  logic [N_REQ-1:0][ADDR_W-1:0]      addr_i;
  logic [N_REQ-1:0]                  wen_i;
  logic [N_REQ-1:0][DATA_W/8-1:0]    be_i;
  logic [N_REQ-1:0][DATA_W-1:0]      wdata_i;
  logic [N_REQ-1:0]                  rvalid_o;
  logic [DATA_W-1:0]                 rdata_o;

  logic                              mem_req_o;
  logic [ADDR_W-1:0]                 mem_addr_o;
  logic                              mem_wen_o;
  logic [DATA_W/8-1:0]               mem_be_o;
  logic [DATA_W-1:0]                 mem_wdata_o;
  logic                              mem_gnt_i;
  logic                              mem_rvalid_i;
  logic [DATA_W-1:0]                 mem_rdata_i;

  modport slave (
    input  req_i, addr_i, wen_i, be_i, wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_addr_o, mem_wen_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_i, addr_i, wen_i, be_i, wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_addr_o, mem_wen_o, mem_be_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/tile_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tile_mem_arbiter -- N-way bank arbiter with stall-based urgency and read-ID FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module tile_mem_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 8,
  parameter int OUTST     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tile_mem_arbiter_if.slave   bus
);
  localparam int CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(OUTST);

  logic [N_REQ-1:0] urgent;
  logic [N_REQ-1:0] gnt;
  logic             win_any, win_vld, fire, push, pop, fifo_full;
  logic [ID_W-1:0]  win_id, head_id;

  logic [ID_W-1:0]  ids_q [OUTST];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_stall
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = '0;
      if (bus.req_i[g] && !gnt[g])
        stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
    end

    assign urgent[g] = (stall_q == STALL_MAX);
  end

  // Descending scans so the lowest index is the last (winning) assignment;
  // the urgent pass overrides the plain pass whenever anyone is urgent.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        win_any = 1'b1;
        win_id  = ID_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i] && urgent[i]) win_id = ID_W'(i);
    end
  end

  assign fifo_full = (occ_q == OCC_FULL);
  assign pop       = bus.mem_rvalid_i && (occ_q != '0) && !rst_i;
  // A full FIFO still admits a grant when a response frees a slot this cycle.
  assign win_vld   = win_any && (!fifo_full || pop) && !rst_i;
  assign fire      = win_vld && bus.mem_gnt_i;
  assign push      = fire && !bus.wen_i[win_id];
  assign head_id   = ids_q[rptr_q];

  for (genvar g = 0; g < N_REQ; g++) begin : g_out
    assign gnt[g]          = fire && (win_id == ID_W'(g));
    assign bus.rvalid_o[g] = pop && (head_id == ID_W'(g));
  end

  assign bus.gnt_o       = gnt;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.mem_req_o   = win_vld;
  assign bus.mem_addr_o  = bus.addr_i[win_id];
  assign bus.mem_wen_o   = bus.wen_i[win_id];
  assign bus.mem_be_o    = bus.be_i[win_id];
  assign bus.mem_wdata_o = bus.wdata_i[win_id];

  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ids_q[wptr_q] <= win_id;
  end

`ifndef SYNTHESIS
  a_no_spurious_rvalid: assert property (
    @(posedge clk_i) disable iff (rst_i) bus.mem_rvalid_i |-> (occ_q != '0)
  ) else $warning("tile_mem_arbiter: mem_rvalid_i with no outstanding read ignored");
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tile_mem_arbiter -- directed scenarios plus random traffic against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tile_mem_arbiter;
  localparam int N_REQ     = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_STALL = 8;
  localparam int OUTST     = 2;
  localparam int BOUND     = N_REQ * (MAX_STALL + 1);

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tile_mem_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_STALL(MAX_STALL), .OUTST(OUTST)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  rd_t               idq[$];
  logic [DATA_W-1:0] respq[$];
  logic [1:0]        hist_gnt[$];
  logic [1:0]        hist_rv[$];
  int                waited[N_REQ];
  int                starve[N_REQ];
  logic [N_REQ-1:0]  last_gnt;
  logic              last_fire_rd;
  int                resp_mode;
  int                mark;

  function automatic logic [DATA_W-1:0] f_data(input logic [ADDR_W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: waiting time per requester, an ID queue for reads.
  always @(negedge clk) begin : cmp
    int               w;
    int               worst;
    bit               can;
    bit               pop;
    logic [N_REQ-1:0] e_gnt;
    logic [N_REQ-1:0] e_rv;
    if (rst) begin
      chk("rst_gnt", 64'(bus.gnt_o), 0);
      chk("rst_mem_req", 64'(bus.mem_req_o), 0);
      chk("rst_rvalid", 64'(bus.rvalid_o), 0);
      idq.delete();
      respq.delete();
      for (int i = 0; i < N_REQ; i++) begin
        waited[i] = 0;
        starve[i] = 0;
      end
      last_gnt     = '0;
      last_fire_rd = 1'b0;
    end else begin
      can = (idq.size() < OUTST) || (bus.mem_rvalid_i && idq.size() != 0);
      w = -1;
      if (can) begin
        for (int i = 0; i < N_REQ; i++)
          if (w < 0 && bus.req_i[i] && waited[i] >= MAX_STALL) w = i;
        for (int i = 0; i < N_REQ; i++)
          if (w < 0 && bus.req_i[i]) w = i;
      end
      e_gnt = '0;
      if (w >= 0 && bus.mem_gnt_i) e_gnt[w] = 1'b1;
      pop  = bus.mem_rvalid_i && idq.size() != 0;
      e_rv = '0;
      if (pop) e_rv[idq[0].id] = 1'b1;

      chk("gnt", 64'(bus.gnt_o), 64'(e_gnt));
      chk("mem_req", 64'(bus.mem_req_o), 64'(w >= 0));
      chk("rvalid", 64'(bus.rvalid_o), 64'(e_rv));
      chk("gnt_onehot0", 64'($onehot0(bus.gnt_o)), 1);
      if (w >= 0) begin
        chk("mem_addr", 64'(bus.mem_addr_o), 64'(bus.addr_i[w]));
        chk("mem_wen", 64'(bus.mem_wen_o), 64'(bus.wen_i[w]));
        chk("mem_be", 64'(bus.mem_be_o), 64'(bus.be_i[w]));
        chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(bus.wdata_i[w]));
      end
      if (pop) chk("rdata", 64'(bus.rdata_o), 64'(idq[0].data));

      if (pop) void'(idq.pop_front());
      if (e_gnt != '0 && !bus.wen_i[w]) idq.push_back('{w, f_data(bus.addr_i[w])});

      worst = 0;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_i[i] && !e_gnt[i]) begin
          waited[i]++;
          if (e_gnt != '0) starve[i]++;
        end else begin
          waited[i] = 0;
          starve[i] = 0;
        end
        if (starve[i] > worst) worst = starve[i];
      end
      checks++;
      if (worst > BOUND) begin
        errors++;
        $display("FAIL wait_bound: got %0d granted cycles waited, limit %0d", worst, BOUND);
      end

      if (bus.mem_rvalid_i && respq.size() != 0) void'(respq.pop_front());
      if (bus.mem_req_o && bus.mem_gnt_i && !bus.mem_wen_o) respq.push_back(f_data(bus.mem_addr_o));
      last_gnt     = bus.gnt_o;
      last_fire_rd = bus.mem_req_o && bus.mem_gnt_i && !bus.mem_wen_o;
    end
    hist_gnt.push_back(bus.gnt_o);
    hist_rv.push_back(bus.rvalid_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (resp_mode)
      1: begin
        bus.mem_rvalid_i = last_fire_rd;
        bus.mem_rdata_i  = (respq.size() != 0) ? respq[0] : '0;
      end
      2: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!bus.req_i[i] || last_gnt[i]) begin
            bus.req_i[i]   = ($urandom_range(0, 3) != 0);
            bus.addr_i[i]  = $urandom;
            bus.wen_i[i]   = ($urandom_range(0, 2) == 0);
            bus.be_i[i]    = 4'($urandom);
            bus.wdata_i[i] = $urandom;
          end
        end
        bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
        bus.mem_rvalid_i = (respq.size() != 0) && ($urandom_range(0, 1) == 1);
        bus.mem_rdata_i  = (respq.size() != 0) ? respq[0] : $urandom;
      end
      default: ;
    endcase
  endtask

  task automatic respond(input bit v);
    bus.mem_rvalid_i = v;
    bus.mem_rdata_i  = (respq.size() != 0) ? respq[0] : 32'hDEAD_BEEF;
  endtask

  initial begin
    rst = 1'b1;
    resp_mode = 0;
    bus.req_i = '0;  bus.addr_i = '0;  bus.wen_i = '0;
    bus.be_i  = '1;  bus.wdata_i = '0;
    bus.mem_gnt_i = 1'b0;  bus.mem_rvalid_i = 1'b0;  bus.mem_rdata_i = '0;

    // Reset holds everything off even with requests and a ready bank.
    bus.req_i = 2'b11;  bus.wen_i = 2'b11;  bus.mem_gnt_i = 1'b1;
    step();
    chk("reset_gnt", 64'(bus.gnt_o), 0);
    chk("reset_mem_req", 64'(bus.mem_req_o), 0);
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(bus.gnt_o), 64'(2'b01));
    step();
    bus.req_i = '0;
    step();

    // Both reading, bank always ready, single-cycle response.
    resp_mode = 1;
    bus.wen_i = 2'b00;
    bus.addr_i[0] = 32'h0000_1000;  bus.addr_i[1] = 32'h0000_2000;
    bus.req_i = 2'b11;
    mark = hist_gnt.size();
    for (int c = 0; c < 12; c++) begin
      step();
      if (last_gnt[0]) bus.addr_i[0] = bus.addr_i[0] + 32'd4;
      if (last_gnt[1]) bus.addr_i[1] = bus.addr_i[1] + 32'd4;
    end
    bus.req_i = '0;
    step();
    step();
    chk("r31_gnt_c0", 64'(hist_gnt[mark]), 64'(2'b01));
    chk("r31_gnt_c7", 64'(hist_gnt[mark + 7]), 64'(2'b01));
    chk("r31_gnt_c8", 64'(hist_gnt[mark + 8]), 64'(2'b10));
    chk("r31_gnt_c9", 64'(hist_gnt[mark + 9]), 64'(2'b01));
    chk("r31_rv_c1", 64'(hist_rv[mark + 1]), 64'(2'b01));
    chk("r31_rv_c9", 64'(hist_rv[mark + 9]), 64'(2'b10));

    // Bank stalled 20 cycles: both counters saturate, the urgent tie goes to
    // index 0, and the still-urgent req1 follows on the very next grant.
    bus.mem_gnt_i = 1'b0;
    bus.req_i = 2'b11;
    mark = hist_gnt.size();
    repeat (20) step();
    bus.mem_gnt_i = 1'b1;
    repeat (3) step();
    bus.req_i = '0;
    step();
    step();
    chk("r32_gnt_c19", 64'(hist_gnt[mark + 19]), 0);
    chk("r32_gnt_c20", 64'(hist_gnt[mark + 20]), 64'(2'b01));
    chk("r32_gnt_c21", 64'(hist_gnt[mark + 21]), 64'(2'b10));
    chk("r32_rv_c21", 64'(hist_rv[mark + 21]), 64'(2'b01));

    // Three reads from req1 with responses withheld: the third waits for a free slot.
    resp_mode = 0;
    respond(1'b0);
    bus.req_i = 2'b10;
    bus.addr_i[1] = 32'h0000_3000;
    mark = hist_gnt.size();
    step();  bus.addr_i[1] = 32'h0000_3004;
    step();  bus.addr_i[1] = 32'h0000_3008;
    step();
    step();  respond(1'b1);
    step();  bus.req_i = '0;  respond(1'b1);
    step();  respond(1'b1);
    step();  respond(1'b0);
    step();
    chk("r33_gnt_c1", 64'(hist_gnt[mark + 1]), 64'(2'b10));
    chk("r33_gnt_c2", 64'(hist_gnt[mark + 2]), 0);
    chk("r33_gnt_c3", 64'(hist_gnt[mark + 3]), 0);
    chk("r33_gnt_c4", 64'(hist_gnt[mark + 4]), 64'(2'b10));
    chk("r33_rv_c4", 64'(hist_rv[mark + 4]), 64'(2'b10));

    // Write from req0 alongside a read from req1: only the read returns.
    bus.req_i = 2'b11;
    bus.wen_i = 2'b01;
    bus.addr_i[0] = 32'h0000_4000;  bus.wdata_i[0] = 32'h1234_5678;  bus.be_i[0] = 4'b0110;
    bus.addr_i[1] = 32'h0000_5000;
    mark = hist_gnt.size();
    step();  bus.req_i = 2'b10;
    step();  bus.req_i = '0;  respond(1'b1);
    step();  respond(1'b0);
    step();
    chk("r34_gnt_c0", 64'(hist_gnt[mark]), 64'(2'b01));
    chk("r34_gnt_c1", 64'(hist_gnt[mark + 1]), 64'(2'b10));
    chk("r34_rv_c2", 64'(hist_rv[mark + 2]), 64'(2'b10));
    bus.wen_i = 2'b00;  bus.be_i = '1;

    // Reset with two reads in flight, then a stray response afterwards.
    bus.req_i = 2'b10;
    bus.addr_i[1] = 32'h0000_6000;
    mark = hist_gnt.size();
    step();  bus.addr_i[1] = 32'h0000_6004;
    step();  rst = 1'b1;
    step();  rst = 1'b0;  bus.req_i = '0;  bus.mem_rvalid_i = 1'b1;  bus.mem_rdata_i = 32'hDEAD_0000;
    step();  bus.mem_rvalid_i = 1'b0;  bus.req_i = 2'b10;  bus.addr_i[1] = 32'h0000_7000;
    step();  bus.addr_i[1] = 32'h0000_7004;
    step();  bus.req_i = '0;  respond(1'b1);
    step();  respond(1'b1);
    step();  respond(1'b0);
    step();
    chk("r35_gnt_in_rst", 64'(hist_gnt[mark + 2]), 0);
    chk("r35_rv_stray", 64'(hist_rv[mark + 3]), 0);
    chk("r35_gnt_c4", 64'(hist_gnt[mark + 4]), 64'(2'b10));
    chk("r35_gnt_c5", 64'(hist_gnt[mark + 5]), 64'(2'b10));
    chk("r35_rv_c6", 64'(hist_rv[mark + 6]), 64'(2'b10));

    // Random traffic with a protocol-respecting requester and bank.
    resp_mode = 2;
    repeat (10000) step();
    resp_mode = 0;
    bus.req_i = '0;
    bus.mem_gnt_i = 1'b1;
    for (int k = 0; k < OUTST + 2; k++) begin
      respond(respq.size() != 0);
      step();
    end
    respond(1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
